// File: rtl/svfloat_pack_arbiter.sv
// svfloat_pack_arbiter: round-robin sharing of one float packer between N_REQ requesters
package svfloat;
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } float32;
endpackage

// svfloat_packer: packs override flags, sign, unbiased exponent and raw mantissa into an IEEE float (truncating)
module svfloat_packer #(
  parameter type float = svfloat::float32,
  parameter int ewidth = 9,
  parameter int width  = 46,
  parameter int frac   = 23
) (
  input  logic                     is_inf,
  input  logic                     is_nan,
  input  logic                     is_zero,
  input  logic                     sign,
  input  logic signed [ewidth-1:0] exp,
  input  logic [width-1:0]         man,
  output float                     res
);
  localparam int FW   = $bits(float);
  localparam int EW   = (FW == 64) ? 11 : (FW == 16) ? 5 : 8;
  localparam int MW   = FW - 1 - EW;
  localparam int PW   = $clog2(width);
  localparam int XW   = ewidth + PW + EW + 2;
  localparam int BIAS = (1 << (EW - 1)) - 1;
  localparam logic signed [XW-1:0] EMAX = XW'((1 << EW) - 1);
  logic [PW-1:0]          pos;
  logic [width-1:0]       norm;
  logic [width-1:0]       den;
  logic signed [XW-1:0]   be;
  logic [XW-1:0]          sh;
  logic [MW-1:0]          field;
  logic [FW-1:0]          r;
  // leading-one position of the raw mantissa (highest set bit wins)
  always_comb begin
    pos = '0;
    for (int b = 0; b < width; b++) if (man[b]) pos = PW'(b);
  end
  // normalise, bias the exponent and shift into the denormal range when needed
  always_comb begin
    norm  = man << (PW'(width - 1) - pos);
    be    = XW'(exp) + $signed(XW'(pos)) + XW'(BIAS - frac);
    sh    = (be > 0) ? '0 : XW'(1) - be;
    den   = norm >> sh;
    field = MW'(den >> (width - 1 - MW));
    r     = is_nan ? {sign, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}} :
            is_inf ? {sign, {EW{1'b1}}, {MW{1'b0}}} :
            (is_zero || man == '0) ? {sign, {(FW-1){1'b0}}} :
            (be >= EMAX) ? {sign, {EW{1'b1}}, {MW{1'b0}}} :
            {sign, (be > 0) ? EW'(be) : {EW{1'b0}}, field};
  end
  assign res = r;
endmodule

module svfloat_pack_arbiter #(
  parameter type float = svfloat::float32,
  parameter int ewidth = 9,
  parameter int width  = 46,
  parameter int frac   = 23,
  parameter int N_REQ  = 4,
  parameter int ID_W   = $clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ-1:0]          req_is_inf,
  input  logic [N_REQ-1:0]          req_is_nan,
  input  logic [N_REQ-1:0]          req_is_zero,
  input  logic [N_REQ-1:0]          req_sign,
  input  logic [N_REQ*ewidth-1:0]   req_exp,
  input  logic [N_REQ*width-1:0]    req_man,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [$bits(float)-1:0]   res_data,
  output logic [ID_W-1:0]           res_id
);
  logic                    res_valid_q;
  logic [$bits(float)-1:0] res_data_q;
  logic [ID_W-1:0]         res_id_q;
  logic [ID_W-1:0]         rr_q;
  logic [N_REQ-1:0]        gnt;
  logic [ID_W-1:0]         gnt_id;
  logic                    found;
  logic                    free;
  logic                    xfer;
  float                    packed_res;
  // first valid requester searching upward from the round-robin pointer
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req_valid[(int'(rr_q) + k) % N_REQ]) begin
        found  = 1'b1;
        gnt_id = ID_W'((int'(rr_q) + k) % N_REQ);
        gnt[(int'(rr_q) + k) % N_REQ] = 1'b1;
      end
    end
  end
  assign free      = !res_valid_q || res_ready;
  assign xfer      = found && free && !rst;
  assign req_ready = xfer ? gnt : '0;
  svfloat_packer #(.float(float), .ewidth(ewidth), .width(width), .frac(frac)) u_packer (
    .is_inf  (req_is_inf[gnt_id]),
    .is_nan  (req_is_nan[gnt_id]),
    .is_zero (req_is_zero[gnt_id]),
    .sign    (req_sign[gnt_id]),
    .exp     (req_exp[gnt_id*ewidth +: ewidth]),
    .man     (req_man[gnt_id*width +: width]),
    .res     (packed_res)
  );
  // one-entry output register; a push replaces any result being popped in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      rr_q        <= '0;
    end else if (xfer) begin
      res_valid_q <= 1'b1;
      res_data_q  <= packed_res;
      res_id_q    <= gnt_id;
      rr_q        <= (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end else if (res_ready) begin
      res_valid_q <= 1'b0;
    end
  end
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
endmodule
